// File: rtl/shift_register_pkg.sv
// Shared types and constants for the universal shift register.
// Provides the shift mode encoding used by the top level and the
// combinational step shifter.
package shift_register_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    SH_SLL = MODE_SLL,
    SH_SRL = MODE_SRL,
    SH_ROL = MODE_ROL,
    SH_ROR = MODE_ROR
  } shift_mode_e;

endpackage

// File: rtl/shift_register_step.sv
// Purely combinational one-bit shifter.
// Ports:
//   data_i    - current register contents
//   mode_i    - shift mode (SLL/SRL/ROL/ROR)
//   serial_i  - fill bit for logical shifts (ignored for rotates)
//   next_o    - contents after one shift
//   out_bit_o - bit leaving the register (the wrapped bit for rotates)
module shift_register_step
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_mode_e      mode_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] next_o,
  output logic             out_bit_o
);

  always_comb begin
    next_o    = data_i;
    out_bit_o = 1'b0;
    case (mode_i)
      SH_SLL: begin
        next_o    = {data_i[WIDTH-2:0], serial_i};
        out_bit_o = data_i[WIDTH-1];
      end
      SH_SRL: begin
        next_o    = {serial_i, data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      SH_ROL: begin
        next_o    = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        out_bit_o = data_i[WIDTH-1];
      end
      SH_ROR: begin
        next_o    = {data_i[0], data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      default: begin
        next_o    = data_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, single-step shifts in four
// modes, serial in/out, and a counted burst-shift engine with busy/done.
// Optional feature macro: SHIFT_REGISTER_PARITY_EN adds parity_out, the
// registered XOR-reduction of data_out.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_en      - parallel load (highest priority, aborts a burst)
//   data_in      - parallel load value
//   shift_en     - single shift with the live mode when idle
//   mode         - 00 SLL, 01 SRL, 10 ROL, 11 ROR
//   serial_in    - fill bit for logical shifts
//   start        - burst request, honoured only when not busy
//   shift_cnt    - burst length in single-bit shifts
//   data_out     - register contents
//   serial_out   - last bit shifted/rotated out
//   busy         - burst in progress
//   done         - one-cycle pulse on burst completion
//   parity_out   - (optional) ^data_out
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REGISTER_PARITY_EN
  ,output logic            parity_out
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q,  rem_d;
  shift_mode_e      mode_q, mode_d;

  shift_mode_e      mode_live;
  shift_mode_e      step_mode;
  logic [WIDTH-1:0] step_next;
  logic             step_out;

  assign mode_live = shift_mode_e'(mode);
  // A running burst uses the mode captured at start, so live mode changes
  // cannot disturb it.
  assign step_mode = busy_q ? mode_q : mode_live;

  shift_register_step #(.WIDTH(WIDTH)) u_step (
    .data_i    (data_q),
    .mode_i    (step_mode),
    .serial_i  (serial_in),
    .next_o    (step_next),
    .out_bit_o (step_out)
  );

  always_comb begin
    data_d = data_q;
    sout_d = sout_q;
    busy_d = busy_q;
    rem_d  = rem_q;
    mode_d = mode_q;
    done_d = 1'b0;
    if (load_en) begin
      // Load wins outright; a running burst is dropped without done.
      data_d = data_in;
      busy_d = 1'b0;
      rem_d  = '0;
    end else if (busy_q) begin
      data_d = step_next;
      sout_d = step_out;
      rem_d  = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      // A zero-length burst completes immediately without ever going busy.
      if (shift_cnt == '0) begin
        done_d = 1'b1;
      end else begin
        mode_d = mode_live;
        rem_d  = shift_cnt;
        busy_d = 1'b1;
      end
    end else if (shift_en) begin
      data_d = step_next;
      sout_d = step_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      mode_q <= SH_SLL;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rem_q  <= rem_d;
      mode_q <= mode_d;
    end
  end

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SHIFT_REGISTER_PARITY_EN
  logic parity_q;

  // Computed from the next-state value so parity tracks data_out exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^data_d;
  end

  assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_shift_register_universal.sv
module tb_shift_register_universal;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic [W-1:0]  data_in;
  logic          shift_en;
  logic [1:0]    mode;
  logic          serial_in;
  logic          start;
  logic [CW-1:0] shift_cnt;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;
`ifdef SHIFT_REGISTER_PARITY_EN
  logic          parity_out;
`endif

  shift_register_universal #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .mode       (mode),
    .serial_in  (serial_in),
    .start      (start),
    .shift_cnt  (shift_cnt),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
`ifdef SHIFT_REGISTER_PARITY_EN
    ,.parity_out(parity_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_en = 0; data_in = '0; shift_en = 0; mode = 2'b00;
    serial_in = 0; start = 0; shift_cnt = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    load_en = 1; data_in = v;
    tick();
    load_en = 0;
  endtask

  // Reference: one shift computed arithmetically from the mode definitions.
  function automatic void ref_shift(input int d, input int md, input int sin,
                                    output int nd, output int ob);
    case (md)
      0: begin nd = ((d * 2) + sin) % 256;            ob = d / 128; end
      1: begin nd = (d / 2) + sin * 128;              ob = d % 2;   end
      2: begin nd = ((d * 2) % 256) + d / 128;        ob = d / 128; end
      default: begin nd = (d / 2) + (d % 2) * 128;    ob = d % 2;   end
    endcase
  endfunction

  typedef struct {
    logic [7:0] init;
    logic [1:0] md;
    logic       sin;
    logic [7:0] exp_d;
    logic       exp_so;
  } vec_t;

  vec_t vecs[11];

  // Model state for the randomized phase.
  int m_data, m_sout, m_busy, m_rem, m_mode, m_done;

  task automatic model_edge();
    int nd, ob;
    if (load_en) begin
      m_data = data_in; m_busy = 0; m_rem = 0; m_done = 0;
    end else if (m_busy != 0) begin
      ref_shift(m_data, m_mode, serial_in, nd, ob);
      m_data = nd; m_sout = ob; m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_busy = 0;
    end else if (start) begin
      if (shift_cnt == 0) m_done = 1;
      else begin m_done = 0; m_busy = 1; m_rem = shift_cnt; m_mode = mode; end
    end else if (shift_en) begin
      ref_shift(m_data, mode, serial_in, nd, ob);
      m_data = nd; m_sout = ob; m_done = 0;
    end else m_done = 0;
  endtask

  initial begin
    vecs[0]  = '{8'hA5, 2'd0, 1'b1, 8'h4B, 1'b1};
    vecs[1]  = '{8'hA5, 2'd1, 1'b0, 8'h52, 1'b1};
    vecs[2]  = '{8'hA5, 2'd2, 1'b0, 8'h4B, 1'b1};
    vecs[3]  = '{8'hA5, 2'd3, 1'b0, 8'hD2, 1'b1};
    vecs[4]  = '{8'h3C, 2'd0, 1'b0, 8'h78, 1'b0};
    vecs[5]  = '{8'h3C, 2'd1, 1'b1, 8'h9E, 1'b0};
    vecs[6]  = '{8'h80, 2'd2, 1'b0, 8'h01, 1'b1};
    vecs[7]  = '{8'h01, 2'd3, 1'b0, 8'h80, 1'b1};
    vecs[8]  = '{8'h01, 2'd1, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{8'h7F, 2'd0, 1'b0, 8'hFE, 1'b0};
    vecs[10] = '{8'h7E, 2'd3, 1'b1, 8'h3F, 1'b0};

    do_reset();
    chk("reset data", data_out, 0);
    chk("reset sout", serial_out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    // Single-step table.
    for (int i = 0; i < 11; i++) begin
      load(vecs[i].init);
      mode = vecs[i].md; serial_in = vecs[i].sin; shift_en = 1;
      tick();
      shift_en = 0;
      chk($sformatf("step%0d data", i), data_out, vecs[i].exp_d);
      chk($sformatf("step%0d sout", i), serial_out, vecs[i].exp_so);
    end
    // Rotate with no further shift holds serial_out.
    tick();
    chk("hold sout", serial_out, 0);

    // Burst ROR 3 on 0x81.
    load(8'h81);
    mode = 2'd3; shift_cnt = 3; start = 1;
    tick();
    start = 0;
    chk("ror E0 busy", busy, 1);
    chk("ror E0 data", data_out, 8'h81);
    tick(); chk("ror E1 data", data_out, 8'hC0); chk("ror E1 busy", busy, 1); chk("ror E1 done", done, 0);
    tick(); chk("ror E2 data", data_out, 8'h60); chk("ror E2 busy", busy, 1);
    tick(); chk("ror E3 data", data_out, 8'h30); chk("ror E3 busy", busy, 0);
    chk("ror done", done, 1); chk("ror sout", serial_out, 0);
    tick(); chk("ror done drop", done, 0);

    // Burst SRL 8 on 0xF0, then zero-count start.
    load(8'hF0);
    mode = 2'd1; serial_in = 0; shift_cnt = 8; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("srl mid done", done, 0);
    end
    tick();
    chk("srl data", data_out, 8'h00);
    chk("srl done", done, 1);
    chk("srl busy", busy, 0);
    shift_cnt = 0; start = 1;
    tick();
    start = 0;
    chk("zero done", done, 1);
    chk("zero busy", busy, 0);
    chk("zero data", data_out, 8'h00);
    tick();
    chk("zero done drop", done, 0);

    // ROL 5 on 0x01: start/shift_en during busy ignored, then load aborts.
    load(8'h01);
    mode = 2'd2; shift_cnt = 5; start = 1;
    tick();
    mode = 2'd0; serial_in = 1; shift_en = 1; shift_cnt = 2;  // start still high
    tick();
    start = 0; shift_en = 0;
    chk("ign data", data_out, 8'h02);
    chk("ign busy", busy, 1);
    load(8'h3C);
    chk("abort data", data_out, 8'h3C);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort no done", done, 0);
      chk("abort hold", data_out, 8'h3C);
    end

    // Async reset mid-burst with remaining=2.
    mode = 2'd2; shift_cnt = 4; start = 1;
    tick();
    start = 0;
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("arst data", data_out, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst no done", done, 0);
      chk("arst no busy", busy, 0);
    end

`ifdef SHIFT_REGISTER_PARITY_EN
    load(8'h07);
    chk("par 07", parity_out, 1);
    mode = 2'd0; serial_in = 0; shift_en = 1;
    tick();
    shift_en = 0;
    chk("par 0E data", data_out, 8'h0E);
    chk("par 0E", parity_out, 1);
    load(8'h03);
    chk("par 03", parity_out, 0);
`endif

    // Randomized phase against the model.
    do_reset();
    m_data = 0; m_sout = 0; m_busy = 0; m_rem = 0; m_mode = 0; m_done = 0;
    for (int i = 0; i < 2000; i++) begin
      load_en   = ($urandom_range(15) == 0);
      data_in   = W'($urandom);
      shift_en  = $urandom_range(1);
      mode      = 2'($urandom);
      serial_in = $urandom_range(1);
      start     = ($urandom_range(3) == 0);
      shift_cnt = CW'($urandom_range(12));
      model_edge();
      tick();
      chk("rnd data", data_out, m_data);
      chk("rnd sout", serial_out, m_sout);
      chk("rnd busy", busy, m_busy);
      chk("rnd done", done, m_done);
`ifdef SHIFT_REGISTER_PARITY_EN
      chk("rnd parity", parity_out, ^(8'(m_data)));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
Parametrised successor to the team's 8-bit load/shift-left register. Adds:
- WIDTH generalisation.
- Four shift modes: logical left/right and rotate left/right.
- Serial in/out.
- A counted burst-shift engine with busy/done handshake.

Used in datapath serialisers and bit-field alignment logic alongside the existing shift register.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 or more.
- CNT_W, $clog2(WIDTH)+1, width of the burst shift count; can encode counts up to WIDTH and beyond.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  parallel load strobe; highest priority
- data_in  in  WIDTH  parallel load value
- shift_en  in  1  single-step shift using live mode
- mode  in  2  00 SLL, 01 SRL, 10 ROL, 11 ROR
- serial_in  in  1  fill bit for SLL/SRL; ignored for rotates
- start  in  1  burst request; accepted only when busy=0
- shift_cnt  in  CNT_W  number of single-bit shifts in the burst
- data_out  out  WIDTH  register contents
- serial_out  out  1  registered copy of the last bit shifted or rotated out
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low rst_n. While rst_n=0: data_out=0, serial_out=0, busy=0, done=0, remaining count=0, latched mode=SLL. Reset mid-burst aborts the burst with no done pulse.
- One-step shift definitions, for data_out=D:
  - SLL: {D[W-2:0],serial_in}, out bit D[W-1].
  - SRL: {serial_in,D[W-1:1]}, out bit D[0].
  - ROL: {D[W-2:0],D[W-1]}.
  - ROR: {D[0],D[W-1:1]}.
  - serial_out takes the out bit on every shift edge and holds otherwise. For rotates the out bit is the wrapped bit.
- Priority per edge: load_en > active burst step > start acceptance > shift_en > hold.
- load_en: data_out<=data_in and serial_out holds. If busy, the burst aborts: busy<=0, remaining<=0, no done.
- Burst start, at edge E0 with start=1, busy=0, load_en=0, shift_cnt=N:
  - N>0: latch mode, remaining<=N, busy<=1. No shift at E0.
  - N=0: busy stays 0, done<=1 for one cycle, data unchanged.
- Burst step, each edge while busy:
  - Shift once using the latched mode; remaining decrements.
  - On the edge where remaining==1: busy<=0 and done<=1.
  - Result: N shifts on edges E1..EN. done and the final data are visible in the cycle after EN.
  - mode changes during a burst have no effect.
- start while busy: ignored, not queued.
- shift_en while busy, or in the same cycle as an accepted start: ignored.
- shift_en when idle: one shift per cycle with the live mode.
- done is 0 in every cycle except the single completion cycle.
- Counts N>WIDTH are legal. Rotates are then periodic; logical shifts keep filling with serial_in sampled on each step edge.

Optional Feature:
- Macro SHIFT_REGISTER_PARITY_EN.
- Defined: adds output parity_out (1 bit), equal to the registered XOR-reduction of the next data_out value.
  - Updates on the same edge as data_out, so it always equals ^data_out.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package shift_register_pkg:
  - typedef enum logic [1:0] shift_mode_e {SH_SLL, SH_SRL, SH_ROL, SH_ROR}.
  - Mode encoding constants.
- One sub-module, shift_register_step: purely combinational one-step shifter.
  - Inputs: data, mode, serial_in.
  - Outputs: next data and out bit.
  - Instantiated once and fed by a mux between live mode and latched mode.
- Burst counter and busy/done logic stay in the top module.

Test Plan (WIDTH=8):
- Reset: assert rst_n=0 mid-burst at remaining=2 -> data_out=0x00, busy=0, done=0 immediately. No done after release.
- Single-step SLL: load 0xA5, then mode=SLL, serial_in=1, shift_en one cycle -> data_out=0x4B, serial_out=1.
- Burst ROR: load 0x81, start with mode=ROR, shift_cnt=3 -> busy high 3 cycles, data_out goes 0xC0, 0x60, 0x30. done pulses once with data_out=0x30 and serial_out=0.
- Burst SRL and zero count: load 0xF0, start SRL, shift_cnt=8, serial_in=0 -> 0x00 after 8 steps, done once. Then start with shift_cnt=0 -> done next cycle, data unchanged, busy stays 0.
- Abort and ignores: during an ROL burst of 5, assert load_en with 0x3C at step 2 -> data_out=0x3C, busy=0, no done. Start and shift_en pulsed while busy are both ignored.
- Parity (macro on): load 0x07 -> parity_out=1. After one SLL with serial_in=0, data_out=0x0E -> parity_out=1. Load 0x03 -> parity_out=0.
